// File: rtl/logfbe_bank_sdpram.sv
// Banked simple-dual-port RAM: byte-enable writes, RD_LATENCY-cycle registered read, all-bank clear sequencer.
// No backpressure: reads every cycle, writes dropped while clearing; LOGFBE_BANK_SDPRAM_BYPASS_EN selects write-first collisions.
module logfbe_bank_sdpram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WIDTH = 2,
  parameter int RD_LATENCY = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic                    wr_clk,
  input  logic                    asyn_rst,
  input  logic                    clr_req,
  output logic                    clr_busy,
  input  logic                    wr_en,
  input  logic [BANK_WIDTH-1:0]   wr_bank,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [BANK_WIDTH-1:0]   rd_bank,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NBE       = DATA_WIDTH / 8;
  localparam int BANK_SLOTS = 2 ** BANK_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] s1_dat;
  logic                  s1_vld;

  // Sized to every bank index so any select is a legal index; slots >= NUM_BANKS are never written or read.
  logic [DATA_WIDTH-1:0] mem [0:BANK_SLOTS-1][0:DEPTH-1];

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) state <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == LAST_ADDR) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = 1'b0;
    if (state == CLEAR) clr_busy = 1'b1;
  end

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst)      clr_cnt <= '0;
    else if (clr_busy) clr_cnt <= clr_cnt + 1'b1;
    else               clr_cnt <= '0;
  end

  assign wr_ok = wr_en && !clr_busy && (32'(wr_bank) < 32'(NUM_BANKS));

  always_ff @(posedge wr_clk) begin
    if (clr_busy) begin
      for (int b = 0; b < NUM_BANKS; b++) mem[b][clr_cnt] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < NBE; k++)
        if (wr_be[k]) mem[wr_bank][wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

  always_comb begin
    rd_word = '0;
    if (32'(rd_bank) < 32'(NUM_BANKS)) rd_word = mem[rd_bank][rd_addr];
`ifdef LOGFBE_BANK_SDPRAM_BYPASS_EN
    // Write-first: merge the enabled bytes of a same-cycle write into the sampled word.
    if (wr_ok && wr_bank == rd_bank && wr_addr == rd_addr) begin
      for (int k = 0; k < NBE; k++)
        if (wr_be[k]) rd_word[8*k +: 8] = wr_data[8*k +: 8];
    end
`endif
  end

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= rd_en;
      if (rd_en) s1_dat <= rd_word;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      always_ff @(posedge wr_clk or posedge asyn_rst) begin
        if (asyn_rst) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= s1_vld;
          if (s1_vld) rd_data <= s1_dat;
        end
      end
    end else begin : g_lat1
      assign rd_valid = s1_vld;
      assign rd_data  = s1_dat;
    end
  endgenerate

endmodule

// File: doc/logfbe_bank_sdpram.md
Name: logfbe_bank_sdpram

Overview:
Multi-bank, single-clock simple-dual-port distributed RAM for the log filterbank-energy path. It holds NUM_BANKS independent buffers, for example one per frame or per channel. Each buffer has one write port and one read port. Features:
- per-byte write enables
- registered read with valid strobe and 1 or 2 cycle latency
- built-in clear sequencer that zeroes every bank after reset or on request

Parameters:
ADDR_WIDTH, 6, word address width per bank, range 4-10
DATA_WIDTH, 16, word width, multiple of 8, range 8-256
NUM_BANKS, 4, number of banks, range 1-16
BANK_WIDTH, 2, bank select width, must be >= ceil(log2(NUM_BANKS)), minimum 1
RD_LATENCY, 1, rd_en to rd_valid latency, 1 or 2
CLR_ON_RST, 1, 1 = run clear sequence automatically after reset release

Ports:
wr_clk  in  1  single clock for both ports
asyn_rst  in  1  reset, asynchronous, active-high
clr_req  in  1  one-cycle pulse, starts a clear of all banks
clr_busy  out  1  high while the clear sequence runs
wr_en  in  1  write strobe
wr_bank  in  BANK_WIDTH  write bank select
wr_addr  in  ADDR_WIDTH  write word address
wr_data  in  DATA_WIDTH  write data
wr_be  in  DATA_WIDTH/8  byte enables; bit k covers wr_data[8k+7:8k]
rd_en  in  1  read strobe
rd_bank  in  BANK_WIDTH  read bank select
rd_addr  in  ADDR_WIDTH  read word address
rd_data  out  DATA_WIDTH  read data, held between reads
rd_valid  out  1  one-cycle pulse, rd_data updated

Behaviour:
- Reset, asynchronous on asyn_rst, all state cleared:
  - rd_data=0, rd_valid=0, pipeline stages=0, clear counter=0.
  - FSM goes to CLEAR if CLR_ON_RST=1, else IDLE; clr_busy mirrors the state.
  - Memory contents are not reset by asyn_rst; only the clear sequence zeroes them.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1.
  - In CLEAR, each cycle writes 0 to address clr_cnt in all banks simultaneously, then clr_cnt++.
  - CLEAR -> IDLE on the cycle the write to address 2**ADDR_WIDTH-1 occurs.
  - A clear therefore takes exactly 2**ADDR_WIDTH cycles; clr_busy is high for exactly those cycles.
  - clr_req while in CLEAR is ignored; the sequence is not restarted.
- Write, IDLE only:
  - On the wr_clk edge with wr_en=1, each byte k with wr_be[k]=1 is written to mem[wr_bank][wr_addr]; other bytes keep their value.
  - wr_en in CLEAR is dropped silently.
- Read:
  - rd_en=1 samples rd_bank and rd_addr.
  - RD_LATENCY=1: rd_data and rd_valid update on the next edge.
  - RD_LATENCY=2: one further register stage; rd_valid is delayed identically.
  - Back-to-back reads are accepted every cycle (full throughput).
  - rd_data holds its last value when no read completes.
  - Reads in CLEAR are serviced normally. Addresses already cleared return 0; uncleared addresses return old contents.
- Out-of-range bank (bank index >= NUM_BANKS): write dropped; read returns 0 with rd_valid still pulsed.
- Read and write to the same bank and address in the same cycle: see Optional Feature. Different addresses are fully independent.
- Reset mid-clear: sequence aborts immediately. After release it restarts from address 0 only if CLR_ON_RST=1.
- Reset mid-read: pending rd_valid pulses are discarded.

Optional Feature:
Macro LOGFBE_BANK_SDPRAM_BYPASS_EN.
- Defined: a same-cycle read/write collision returns write-first data. Bytes with wr_be=1 take wr_data; the rest take the old memory bytes. This is implemented by forwarding at the read sample stage.
- Undefined: a collision returns the old (pre-write) word, read-first. No forwarding logic is generated.
- Latency is identical in both builds.

Test Plan:
1. Reset with ADDR_WIDTH=6, CLR_ON_RST=1, memory preloaded nonzero -> clr_busy high for exactly 64 cycles after release; afterwards reads of all 4 banks at all addresses return 0x0000.
2. Write bank2 addr 0x15 data 0xA55A be=11, then rd_en bank2 addr 0x15 -> rd_data=0xA55A with rd_valid one cycle later (RD_LATENCY=1) or two cycles later (RD_LATENCY=2). Streaming reads of 8 consecutive addresses -> 8 consecutive rd_valid pulses.
3. Byte enables: word holds 0x1234; write 0xABCD with be=01 -> read 0x12CD. Write with be=10 -> read 0xAB CD merged as 0xABCD.
4. Collision: word holds 0x1111; same-cycle write 0x2222 be=11 and read of that address -> 0x2222 with macro defined, 0x1111 without. A subsequent read returns 0x2222 in both builds.
5. clr_req pulse in IDLE, with wr_en asserted during the clear and a second clr_req at cycle 10 -> writes dropped, clear still completes in 64 cycles, all words read 0.
6. Edge cases:
   - asyn_rst at cycle 20 of a clear with CLR_ON_RST=0 -> clr_busy=0 immediately; addresses 0-19 read 0, others keep old data.
   - Read of bank 5 with NUM_BANKS=4, BANK_WIDTH=3 -> rd_data=0 with rd_valid=1.
